sram_arbiter: RTL and testbench

- Sequences the single external 8-bit asynchronous SRAM and shares it between two requesters: the CPU bus side (read/write) and the CGA video fetch (read-only).
- Video fetch has priority; a starvation limiter guarantees CPU progress.
- Generates SRAM address, write-enable strobe and data-driver enable with programmable read and write timing, in the chipset clock domain.
- The top level builds the SRAM_DATA tri-state from sram_dout and sram_oe.

---
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shares one external 8-bit asynchronous SRAM between the CPU bus and the CGA video fetch.
// Video has priority; a streak limiter forces a CPU grant after VID_BURST_MAX video grants.
module sram_arbiter #(
  parameter int ADDR_WIDTH    = 21,
  parameter int READ_CYCLES   = 2,
  parameter int WE_CYCLES     = 2,
  parameter int VID_BURST_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic [7:0]            vid_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_dout,
  output logic                  sram_oe,
  input  logic [7:0]            sram_din,
  output logic                  sram_we_n,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD,
    S_RECOVER
  } state_t;

  state_t                state_reg, state_next;
  logic [3:0]            phase_reg, phase_next;
  logic [3:0]            streak_reg, streak_next;
  logic                  owner_vid_reg, owner_vid_next;
  logic [ADDR_WIDTH-1:0] sram_addr_next;
  logic [7:0]            sram_dout_next;
  logic                  grant_vid, grant_cpu, capture;

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    streak_next    = streak_reg;
    owner_vid_next = owner_vid_reg;
    sram_addr_next = sram_addr;
    sram_dout_next = sram_dout;
    grant_vid      = 1'b0;
    grant_cpu      = 1'b0;
    capture        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (vid_req && !(cpu_req && streak_reg == 4'(VID_BURST_MAX))) begin
          grant_vid = 1'b1;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
        end

        // Streak only counts video wins that actually kept the CPU waiting
        if (!cpu_req || grant_cpu) begin
          streak_next = '0;
        end else if (grant_vid && streak_reg != 4'(VID_BURST_MAX)) begin
          streak_next = streak_reg + 4'd1;
        end

        if (grant_vid) begin
          owner_vid_next = 1'b1;
          sram_addr_next = vid_addr;
          phase_next     = 4'(READ_CYCLES - 1);
          state_next     = S_READ;
        end else if (grant_cpu) begin
          owner_vid_next = 1'b0;
          sram_addr_next = cpu_addr;
          sram_dout_next = cpu_wdata;
          phase_next     = 4'(READ_CYCLES - 1);
          state_next     = cpu_we ? S_WSETUP : S_READ;
        end
      end
      S_READ: begin
        if (phase_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = S_RECOVER;
        end else begin
          phase_next = phase_reg - 4'd1;
        end
      end
      S_WSETUP: begin
        phase_next = 4'(WE_CYCLES - 1);
        state_next = S_WPULSE;
      end
      S_WPULSE: begin
        if (phase_reg == 4'd0) begin
          state_next = S_WHOLD;
        end else begin
          phase_next = phase_reg - 4'd1;
        end
      end
      S_WHOLD:   state_next = S_RECOVER;
      S_RECOVER: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Strobes and acks are registered from the next state so they never glitch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      phase_reg     <= '0;
      streak_reg    <= '0;
      owner_vid_reg <= 1'b0;
      sram_addr     <= '0;
      sram_dout     <= '0;
      sram_oe       <= 1'b0;
      sram_we_n     <= 1'b1;
      cpu_ack       <= 1'b0;
      vid_ack       <= 1'b0;
      cpu_rdata     <= '0;
      vid_rdata     <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      streak_reg    <= streak_next;
      owner_vid_reg <= owner_vid_next;
      sram_addr     <= sram_addr_next;
      sram_dout     <= sram_dout_next;
      sram_oe       <= (state_next == S_WSETUP) || (state_next == S_WPULSE) ||
                       (state_next == S_WHOLD);
      sram_we_n     <= (state_next != S_WPULSE);
      cpu_ack       <= (state_next == S_RECOVER) && !owner_vid_next;
      vid_ack       <= (state_next == S_RECOVER) && owner_vid_next;
      if (capture) begin
        if (owner_vid_reg) begin
          vid_rdata <= sram_din;
        end else begin
          cpu_rdata <= sram_din;
        end
      end
    end
  end

  assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected acks, a monitor checks each ack
// plus the strobe activity seen since the previous ack.
module tb_sram_arbiter;

  localparam int AW = 21;
  localparam int WE = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_addr, vid_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack, vid_ack;
  logic [7:0]    cpu_rdata, vid_rdata;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dout, sram_din;
  logic          sram_oe, sram_we_n, busy;

  sram_arbiter #(
    .ADDR_WIDTH(AW), .READ_CYCLES(2), .WE_CYCLES(WE), .VID_BURST_MAX(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_oe(sram_oe),
    .sram_din(sram_din), .sram_we_n(sram_we_n), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // SRAM model: unwritten locations return a fixed pattern, 0x00123 holds 0x5A
  logic [7:0] mem [logic [AW-1:0]];
  always @(posedge sram_we_n) begin
    if (reset_n === 1'b1) mem[sram_addr] = sram_dout;
  end
  always @(negedge clock) begin
    if (mem.exists(sram_addr)) sram_din = mem[sram_addr];
    else if (sram_addr == 21'h00123) sram_din = 8'h5A;
    else sram_din = sram_addr[7:0] ^ 8'hA5;
  end

  typedef struct {
    bit            is_vid;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            ack_cyc;
    int            we_first;
  } exp_t;

  exp_t exp_q[$];
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  // Monitor: sole consumer of the scoreboard and owner of the counters
  initial begin
    int   rd_idx = 0;
    int   we_cnt = 0;
    int   oe_cnt = 0;
    int   we_first = -1;
    bit   wbad = 1'b0;
    logic [7:0] last_cpu_rd = 8'h00;
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) break;
      if (cyc_cnt > 20000) begin
        failures++;
        $display("FAIL watchdog actual=%0d cycles required=<20000", cyc_cnt);
        break;
      end
      if (!reset_n) begin
        chk("reset_ctrl", {27'd0, sram_we_n, sram_oe, busy, cpu_ack, vid_ack}, 32'h10);
        chk("reset_data", {sram_addr, sram_dout, cpu_rdata, vid_rdata}, 32'h0);
        we_cnt = 0; oe_cnt = 0; we_first = -1; wbad = 1'b0; last_cpu_rd = 8'h00;
        continue;
      end
      if (!sram_we_n) begin
        we_cnt++;
        if (we_first < 0) we_first = cyc_cnt;
        if (!sram_oe) wbad = 1'b1;
      end
      if (sram_oe) begin
        oe_cnt++;
        if (rd_idx < exp_q.size() && exp_q[rd_idx].is_wr &&
            (sram_dout !== exp_q[rd_idx].data || sram_addr !== exp_q[rd_idx].addr))
          wbad = 1'b1;
      end
      if (cpu_ack || vid_ack) begin
        if (rd_idx >= exp_q.size()) begin
          chk("unexpected_ack", {30'd0, cpu_ack, vid_ack}, 32'd0);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          chk("ack_owner", {30'd0, cpu_ack, vid_ack}, e.is_vid ? 32'd1 : 32'd2);
          chk("ack_addr", 32'(sram_addr), 32'(e.addr));
          if (e.ack_cyc >= 0) chk("ack_cycle", cyc_cnt, e.ack_cyc);
          if (e.is_vid) begin
            chk("vid_rdata", 32'(vid_rdata), 32'(e.data));
          end else if (e.is_wr) begin
            chk("wr_keeps_rdata", 32'(cpu_rdata), 32'(last_cpu_rd));
            chk("we_first", we_first, e.we_first);
          end else begin
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            last_cpu_rd = e.data;
          end
          chk("we_low_cycles", we_cnt, e.is_wr ? WE : 0);
          chk("oe_cycles", oe_cnt, e.is_wr ? WE + 2 : 0);
          chk("write_bus_stable", {31'd0, wbad}, 32'd0);
        end
        we_cnt = 0; oe_cnt = 0; we_first = -1; wbad = 1'b0;
      end
    end
    chk("all_acks_seen", rd_idx, exp_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic [7:0] rd_exp);
    int t;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    t = cyc_cnt;
    exp_q.push_back('{is_vid: 1'b0, is_wr: we, addr: a, data: we ? d : rd_exp,
                      ack_cyc: t + (we ? WE + 3 : 3), we_first: t + 2});
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (cpu_ack) break;
    end
    cpu_req = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    int t;
    int n;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);

    cpu_op(1'b0, 21'h00123, 8'h00, 8'h5A);
    cpu_op(1'b1, 21'h1FFFF, 8'hC3, 8'h00);
    cpu_op(1'b0, 21'h1FFFF, 8'h00, 8'hC3);

    // Both requesters held: four video grants, then the CPU, twice over
    @(posedge clock); #1;
    vid_req = 1'b1; vid_addr = 21'hB8010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00123;
    t = cyc_cnt;
    for (int k = 0; k < 10; k++) begin
      bit v;
      v = (k % 5) != 4;
      exp_q.push_back('{is_vid: v, is_wr: 1'b0, addr: v ? 21'hB8010 : 21'h00123,
                        data: v ? 8'hB5 : 8'h5A, ack_cyc: t + 3 + 4 * k, we_first: -1});
    end
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(posedge clock); #1;
      if (cpu_ack || vid_ack) n++;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (3) @(posedge clock);

    // Back-to-back video reads
    @(posedge clock); #1;
    vid_req = 1'b1; vid_addr = 21'hB8000;
    t = cyc_cnt;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] lo;
      lo = 8'(k);
      exp_q.push_back('{is_vid: 1'b1, is_wr: 1'b0, addr: 21'hB8000 + 21'(k),
                        data: lo ^ 8'hA5, ack_cyc: t + 3 + 4 * k, we_first: -1});
    end
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(posedge clock); #1;
      if (vid_ack) begin
        n++;
        vid_addr = 21'hB8000 + 21'(n);
      end
    end
    vid_req = 1'b0;
    repeat (3) @(posedge clock);

    // Reset during the write pulse: no ack expected for the aborted write
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h00500; cpu_wdata = 8'h77;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (!sram_we_n) break;
    end
    #1;
    reset_n = 1'b0; cpu_req = 1'b0;
    @(posedge clock); @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    cpu_op(1'b0, 21'h00456, 8'h00, 8'hF3);

    // Request dropped right after the grant still completes exactly once
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00789;
    t = cyc_cnt;
    exp_q.push_back('{is_vid: 1'b0, is_wr: 1'b0, addr: 21'h00789, data: 8'h2C,
                      ack_cyc: t + 3, we_first: -1});
    @(posedge clock); #1;
    cpu_req = 1'b0;
    repeat (10) @(posedge clock);

    done = 1'b1;
  end

endmodule
